// File: rtl/ro_entropy_ctrl.sv
// Ring-oscillator TRNG controller: enables the RO bank, waits out warm-up, samples the
// RO outputs through 2-flop synchronizers, XORs them to one raw bit per tick and packs
// the bits MSB-first into words. Configurable with RO_HEALTH_TEST_EN (repetition-count test).
// Latency: first word is valid WARMUP_CYCLES + SAMPLE_DIV*WORD_W cycles after the start edge.
// Backpressure: one word waits on the output and one more is parked internally (HOLD, sampling
// frozen); a word is never dropped or overwritten until stop or reset.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   start, stop         : 1-cycle control pulses (stop wins over everything)
//   ro_en / ro_in       : per-cell RO enables (registered) and raw asynchronous RO outputs
//   word_data/_valid/_ready : packed output word with valid/ready handshake
//   busy                : high whenever the controller is not idle
//   health_alarm        : sticky repetition-test failure (constant 0 without the macro)
module ro_entropy_ctrl #(
  parameter int NUM_RO        = 8,
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 4,
  parameter int WORD_W        = 32,
  parameter int REP_LIMIT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [NUM_RO-1:0] ro_en,
  input  logic [NUM_RO-1:0] ro_in,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              health_alarm
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int DCW = $clog2(SAMPLE_DIV + 1);
  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SAMPLE_DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);

  if (NUM_RO < 1 || NUM_RO > 32 || WARMUP_CYCLES < 1 || SAMPLE_DIV < 1 ||
      WORD_W < 2 || WORD_W > 64 || REP_LIMIT < 2) begin : g_param_check
    $error("ro_entropy_ctrl: parameter out of range");
  end

`ifdef RO_HEALTH_TEST_EN
  typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, HOLD, FAULT} state_e;
  localparam int RCW = $clog2(REP_LIMIT + 1);
  localparam logic [RCW-1:0] REP_MAX = RCW'(REP_LIMIT);
  logic [RCW-1:0] rep_q, rep_d, rep_nxt;
  logic           last_q, last_d, alarm_q, alarm_d;
`else
  typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, HOLD} state_e;
`endif

  state_e            state_q, state_d;
  logic [NUM_RO-1:0] sync1_q, sync2_q, ro_en_q, ro_en_d;
  logic [WCW-1:0]    warm_q, warm_d;
  logic [DCW-1:0]    div_q, div_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d, data_q, data_d, shift_nxt;
  logic              valid_q, valid_d, raw_bit, xfer;

  // Synchronizers run regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ro_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw_bit   = ^sync2_q;
  assign shift_nxt = {shift_q[WORD_W-2:0], raw_bit};
  assign xfer      = valid_q & word_ready;
`ifdef RO_HEALTH_TEST_EN
  // rep_q==0 marks "no previous tick", so the first tick always starts a run of 1.
  assign rep_nxt = (rep_q != '0 && raw_bit == last_q) ? rep_q + 1'b1 : RCW'(1);
`endif

  always_comb begin
    state_d = state_q;
    ro_en_d = ro_en_q;
    warm_d  = warm_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef RO_HEALTH_TEST_EN
    rep_d   = rep_q;
    last_d  = last_q;
    alarm_d = alarm_q;
`endif
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      ro_en_d = '0;
      valid_d = 1'b0;
      warm_d  = '0;
      div_d   = '0;
      bit_d   = '0;
      shift_d = '0;
`ifdef RO_HEALTH_TEST_EN
      rep_d   = '0;
      last_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = WARMUP;
            ro_en_d = '1;
            warm_d  = '0;
          end
        end
        WARMUP: begin
          if (warm_q == WARM_LAST) begin
            state_d = SAMPLE;
            div_d   = '0;
            bit_d   = '0;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        SAMPLE: begin
          if (xfer) valid_d = 1'b0;
          if (div_q == DIV_LAST) begin
            div_d = '0;
`ifdef RO_HEALTH_TEST_EN
            rep_d  = rep_nxt;
            last_d = raw_bit;
            if (rep_nxt == REP_MAX) begin
              // The failing tick never produces a word.
              state_d = FAULT;
              ro_en_d = '0;
              valid_d = 1'b0;
              alarm_d = 1'b1;
            end else
`endif
            begin
              shift_d = shift_nxt;
              if (bit_q == BIT_LAST) begin
                bit_d = '0;
                if (!valid_q || xfer) begin
                  data_d  = shift_nxt;
                  valid_d = 1'b1;
                end else begin
                  // Output slot busy: the finished word stays in shift_q while sampling pauses.
                  state_d = HOLD;
                end
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        HOLD: begin
          // word_valid is always 1 here, so word_ready alone means a transfer.
          if (word_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = SAMPLE;
          end
        end
`ifdef RO_HEALTH_TEST_EN
        FAULT: ;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ro_en_q <= '0;
      warm_q  <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef RO_HEALTH_TEST_EN
      rep_q   <= '0;
      last_q  <= 1'b0;
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ro_en_q <= ro_en_d;
      warm_q  <= warm_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef RO_HEALTH_TEST_EN
      rep_q   <= rep_d;
      last_q  <= last_d;
      alarm_q <= alarm_d;
`endif
    end
  end

  assign ro_en      = ro_en_q;
  assign word_data  = data_q;
  assign word_valid = valid_q;
  assign busy       = (state_q != IDLE);
`ifdef RO_HEALTH_TEST_EN
  assign health_alarm = alarm_q;
`else
  assign health_alarm = 1'b0;
`endif

endmodule

// File: doc/ro_entropy_ctrl.md
Name: ro_entropy_ctrl

Overview:
Controller that sequences a bank of ring-oscillator cells for the TRNG. It gates each cell's enable, waits for the oscillators to warm up, and samples their asynchronous outputs through 2-flop synchronizers. It XOR-combines the samples into one raw bit per sample tick, packs the bits into words, and hands each word downstream on a valid/ready interface.

Parameters:
NUM_RO, 8, number of RO cells driven and sampled (1..32)
WARMUP_CYCLES, 64, clk cycles between enabling the ROs and the first sample (>=1)
SAMPLE_DIV, 4, clk cycles per raw-bit sample tick (>=1)
WORD_W, 32, raw bits packed per output word (2..64)
REP_LIMIT, 16, repeat-count threshold, used only with the optional feature (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse; begin generation when in IDLE
stop  input  1  1-cycle pulse; abort to IDLE from any state
ro_en  output  NUM_RO  enable to each RO cell (registered)
ro_in  input  NUM_RO  RO cell outputs (asynchronous to clk)
word_data  output  WORD_W  packed random word
word_valid  output  1  word_data holds a valid word
word_ready  input  1  downstream accepts word_data
busy  output  1  high in every state except IDLE
health_alarm  output  1  sticky failure flag; tied 0 unless RO_HEALTH_TEST_EN is defined

Behaviour:
- Reset values: ro_en=0, word_data=0, word_valid=0, busy=0, health_alarm=0, state=IDLE. All counters, the shift register and the synchronizers are 0.
- Synchronizer: ro_in passes through two flops (sync1, sync2). raw_bit = XOR reduction of sync2. Synchronizers run continuously.
- FSM states: IDLE, WARMUP, SAMPLE, HOLD (plus FAULT when the optional feature is compiled in).
- IDLE: ro_en=0. On start, go to WARMUP; ro_en becomes all-ones on the next edge and the warm-up counter clears.
- WARMUP: counter increments each cycle. When the count reaches WARMUP_CYCLES-1, go to SAMPLE and clear the divider and bit counter.
- SAMPLE: divider counts 0..SAMPLE_DIV-1 and wraps.
  - Tick when divider==SAMPLE_DIV-1: shift register <= {shift[WORD_W-2:0], raw_bit}; bit count +1.
  - On the tick that completes bit WORD_W: word_data <= new shift value, word_valid <= 1, bit count clears.
  - SAMPLE_DIV=1 means a tick every cycle.
- Handshake: a transfer occurs when word_valid & word_ready on a rising edge.
  - word_data is stable while word_valid=1 and ready=0.
  - word_valid drops the cycle after the transfer unless a new word completes on that same edge; in that case valid stays 1 and data updates.
- HOLD: entered when a word completes while the previous word is still unaccepted (valid=1, no transfer that edge). The new word is kept internally and sampling pauses (divider frozen, ROs stay enabled). When the pending word transfers, the kept word loads into word_data with valid=1 and the FSM returns to SAMPLE. No word is ever dropped or overwritten.
- stop (any non-IDLE state): next edge goes to IDLE with ro_en=0, word_valid=0, and counters and shift register cleared. An unaccepted word is discarded. stop has priority over start and over a simultaneous tick or transfer.
- start outside IDLE is ignored.
- Async reset mid-operation returns everything to reset values immediately; ro_en=0 stops the oscillators.
- Widths: counters sized $clog2(max+1), with no overflow at maximum parameter values.

Optional Feature:
Macro RO_HEALTH_TEST_EN.
- Defined: repetition-count test on raw_bit at each tick. If raw_bit equals the previous tick's bit, the run count increments, otherwise it resets to 1. When the run reaches REP_LIMIT, go to FAULT: ro_en=0, word_valid=0, health_alarm=1 (sticky). FAULT is left only via stop (to IDLE, alarm stays set) or reset (alarm clears). start is ignored in FAULT.
- Not defined: no run counter, no FAULT state, health_alarm constant 0.

Test Plan:
- Reset/idle: hold rst_n=0, then release with start=0 for 100 cycles -> ro_en=0, word_valid=0, busy=0 throughout.
- Warm-up timing: defaults, pulse start at cycle T -> ro_en=8'hFF at T+1; first tick at T+1+64+4-1; word_valid rises after 32 ticks.
- Known data: ro_in driven synchronously with a pattern whose XOR gives 1,0,1,1,... per tick, WORD_W=8, SAMPLE_DIV=1 -> word_data=8'b1011_xxxx per the pattern, MSB = first bit.
- Backpressure: word_ready=0 for 3 word periods -> second word held in HOLD, sampling paused; on raising ready, exactly 2 words transfer in order, none lost.
- stop mid-SAMPLE with valid=1, ready=0 -> next cycle IDLE, ro_en=0, word_valid=0; a later start restarts warm-up from 0.
- RO_HEALTH_TEST_EN defined, ro_in held constant, REP_LIMIT=16 -> FAULT after the 16th tick, health_alarm=1, ro_en=0; stop -> IDLE with alarm still 1; reset clears it.
